or_source_decoder: RTL
======================

Name: or_source_decoder

Overview:
- Inverse companion of the lab's OR-combining logic: it reports which input caused the combined OR line to assert.
- Synchronizes N asynchronous request lines (switches/buttons) and produces the combined OR level.
- On each new rising edge, captures the lowest-index rising source as a one-hot code plus a binary index, and holds it until acknowledged.
- Sits between board inputs and downstream LED/display logic.

Parameters:
- N, 3, number of request inputs (2..16)
- SYNC_STAGES, 2, synchronizer flop depth per input (≥2)
- CNT_W, 8, width of the event and miss counters

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- in_req  input  N  asynchronous request lines, active-high
- any_o  output  1  OR of synchronized request lines
- event_valid  output  1  captured event pending
- event_src  output  N  one-hot captured source, valid while event_valid
- event_idx  output  $clog2(N)  binary index of the captured source
- event_multi  output  1  more than one input rose in the capture cycle
- event_ack  input  1  consumer acknowledge
- event_cnt  output  CNT_W  total captured events, saturating
- miss_cnt  output  CNT_W  rises dropped while an event was held, saturating

Behaviour:
- Reset: clk is the only clock. resetn is asynchronous and active-low. While resetn=0:
  - all synchronizer flops and edge-history flops = 0
  - FSM = IDLE
  - event_valid = 0, event_src = 0, event_idx = 0, event_multi = 0
  - event_cnt = 0, miss_cnt = 0; any_o therefore = 0
  - Reset mid-HOLD discards the pending event; no ack is needed afterwards.
- Synchronizer: each in_req bit passes through SYNC_STAGES flops. sync = last stage.
- any_o: combinational OR of sync. It asserts SYNC_STAGES edges after the input rises.
- Edge detect: prev = sync delayed one clock. rise = sync & ~prev (combinational). A level held high produces exactly one rise.
- FSM has two states, IDLE and HOLD:
  - IDLE, rise≠0, on the clock edge:
    - event_src ← lowest set bit of rise; event_idx ← its index
    - event_multi ← (popcount(rise) > 1)
    - event_valid ← 1; event_cnt += 1, saturating at 2^CNT_W−1
    - FSM → HOLD
  - IDLE, rise=0: hold state. event_ack in IDLE is ignored.
  - HOLD: event_src, event_idx and event_multi are stable. Each cycle with rise≠0 increments miss_cnt by 1 (per cycle, not per bit), saturating.
  - HOLD, event_ack=1 on the clock edge: event_valid ← 0, FSM → IDLE. event_src, event_idx and event_multi are NOT cleared; they keep their last values.
  - A rise in the same cycle as the ack counts as a miss. It is not captured, and it will not re-trigger because prev is already high.
- Latency: input rise to event_valid=1 is SYNC_STAGES+1 clock edges (3 at default). Ack to event_valid=0 is 1 edge.
- Back-to-back events: after an ack, the earliest next capture is the following cycle.
- Falling edges are never reported. An input must fall and rise again to generate a new event.
- Counters wrap never: both saturate and stay saturated until reset.
- N not a power of two: unused event_idx codes never appear.

Test Plan:
- Reset then idle: in_req=000 for 10 cycles → any_o=0, event_valid=0, both counters 0.
- Single rise: in_req 000→010, held → any_o=1 after 2 edges; event_valid=1 after 3 edges with event_src=010, event_idx=1, event_multi=0, event_cnt=1. Ack 1 cycle → event_valid=0 next edge. No re-trigger while in_req stays 010.
- Simultaneous rise: in_req 000→110 in one cycle → event_src=010, event_idx=1, event_multi=1, event_cnt=1.
- Miss while held: capture in_req[0], then toggle in_req[2] 0→1→0→1 before ack → miss_cnt=2, event_src still 001. After ack, in_req[1] rise → new capture, event_cnt=2.
- Ack-cycle collision: in_req[2] rise sampled on the same edge as event_ack → miss_cnt +1, event_valid=0, no capture.
- Saturation and reset: CNT_W=2, 5 capture/ack pairs → event_cnt=3. Assert resetn=0 mid-HOLD asynchronously (between clock edges) → event_valid=0 and counters 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/or_source_decoder.sv
// or_source_decoder
//   Companion to the board's OR-combining logic: tells downstream logic which
//   request line made the combined OR assert.
//   Each request line is synchronized and edge-detected in its own lane. On a
//   new rising edge the lowest-index rising source is captured as a one-hot
//   code plus a binary index. The capture is held until the consumer
//   acknowledges it.
//
// Ports
//   clk, resetn  system clock; asynchronous active-low reset
//   in_req       [N]       asynchronous request lines, active-high
//   any_o                  OR of the synchronized request lines
//   event_valid            a captured event is pending
//   event_src    [N]       one-hot captured source
//   event_idx    [IDX_W]   binary index of the captured source
//   event_multi            more than one line rose in the capture cycle
//   event_ack              consumer acknowledge (ignored when nothing is held)
//   event_cnt    [CNT_W]   total captured events, saturating
//   miss_cnt     [CNT_W]   cycles with rises dropped while holding, saturating

// Per-line synchronizer plus rising-edge detector.
module or_source_decoder_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic req_i,
  output logic sync_o,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  // A level held high gives exactly one rise, because prev follows sync.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

module or_source_decoder #(
  parameter int N           = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         in_req,
  output logic                 any_o,
  output logic                 event_valid,
  output logic [N-1:0]         event_src,
  output logic [$clog2(N)-1:0] event_idx,
  output logic                 event_multi,
  input  logic                 event_ack,
  output logic [CNT_W-1:0]     event_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic [N-1:0]     src;
    logic [IDX_W-1:0] idx;
    logic             multi;
  } evt_t;

  logic [N-1:0] sync, rise;

  for (genvar g = 0; g < N; g++) begin : g_lane
    or_source_decoder_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .req_i  (in_req[g]),
      .sync_o (sync[g]),
      .rise_o (rise[g])
    );
  end

  assign any_o = |sync;

  // Lowest set bit of rise: scanning from the top down lets the lowest
  // index win. Only real lane indices are ever produced, so unused codes of
  // a non-power-of-two N cannot appear.
  logic [N-1:0]     low_oh;
  logic [IDX_W-1:0] low_idx;
  logic             rise_multi;

  always_comb begin
    low_oh  = '0;
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rise[i]) begin
        low_oh    = '0;
        low_oh[i] = 1'b1;
        low_idx   = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more rose.
  assign rise_multi = |(rise & (rise - N'(1)));

  state_t           state_q, state_d;
  evt_t             evt_q, evt_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    state_d    = state_q;
    evt_d      = evt_q;
    evt_cnt_d  = evt_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (|rise) begin
          evt_d   = '{src: low_oh, idx: low_idx, multi: rise_multi};
          state_d = HOLD;
          if (evt_cnt_q != '1) evt_cnt_d = evt_cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // One miss per cycle, however many lines rose. A rise that arrives
        // with the ack is dropped too; it never re-triggers because prev is
        // already high by the next cycle.
        if ((|rise) && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        // The captured fields are left in place on ack.
        if (event_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      evt_q      <= '0;
      evt_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      evt_q      <= evt_d;
      evt_cnt_q  <= evt_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign event_valid = (state_q == HOLD);
  assign event_src   = evt_q.src;
  assign event_idx   = evt_q.idx;
  assign event_multi = evt_q.multi;
  assign event_cnt   = evt_cnt_q;
  assign miss_cnt    = miss_cnt_q;
endmodule
